flash_sample_reader: RTL and testbench

Downstream of the keyboard control stage: it turns the play enable, direction and restart commands into Avalon-MM reads of the audio image in flash, and emits one signed 16-bit sample per 22 kHz tick. Each 32-bit flash word holds two samples. The block returns `flash_read_finished` to the keyboard control stage each time it delivers a sample. Its only downstream consumer is the audio output path.

---
 rtl/flash_sample_reader_if.sv | 11 +
 rtl/flash_sample_reader.sv | 118 +++++++++++
 tb/tb_flash_sample_reader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/flash_sample_reader_if.sv
// flash_sample_reader_if: Avalon-MM read-only flash bus between the sample reader (master) and flash (slave).
interface flash_sample_reader_if #(parameter int ADDR_W = 23);
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;
  modport master (output read, address, byteenable, input waitrequest, readdata, readdatavalid);
  modport slave (input read, address, byteenable, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: fetches two-sample flash words and plays one half-word per sample tick.
// Define FLASH_READER_OVERRUN_CNT_EN to add the overrun_cnt dropped-tick counter.
module flash_sample_reader #(
  parameter int ADDR_W = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic start_read_flash,
  input  logic dir,
  input  logic restart,
  flash_sample_reader_if.master mem,
  output logic [15:0] audio_data,
  output logic audio_valid,
  output logic flash_read_finished
`ifdef FLASH_READER_OVERRUN_CNT_EN
  , output logic [15:0] overrun_cnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_DATA = 2'd2, HALF = 2'd3;
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_next, addr_restart;
  logic word_dir_q, word_dir_d, restart_pending_q, restart_pending_d, valid_q, valid_d;
  logic [15:0] half_q, half_d, audio_q, audio_d;
  logic play_tick, drop;
  assign play_tick = sample_tick && start_read_flash;
  assign addr_next = word_dir_q ? (addr_q == LAST_ADDR ? '0 : addr_q + 1'b1)
                                : (addr_q == '0 ? LAST_ADDR : addr_q - 1'b1);
  assign addr_restart = dir ? '0 : LAST_ADDR;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    word_dir_d = word_dir_q;
    restart_pending_d = restart_pending_q;
    half_d = half_q;
    audio_d = audio_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (restart) addr_d = addr_restart;
        else if (play_tick) begin
          word_dir_d = dir;
          state_d = REQ;
        end
      end
      REQ: begin
        restart_pending_d = restart_pending_q || restart;
        if (!mem.waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        restart_pending_d = restart_pending_q || restart;
        // a restart requested mid-read still lets the bus transfer finish, then drops the word
        if (mem.readdatavalid) begin
          restart_pending_d = 1'b0;
          if (restart_pending_q || restart) begin
            addr_d = addr_restart;
            state_d = IDLE;
          end else begin
            audio_d = word_dir_q ? mem.readdata[15:0] : mem.readdata[31:16];
            half_d = word_dir_q ? mem.readdata[31:16] : mem.readdata[15:0];
            valid_d = 1'b1;
            state_d = HALF;
          end
        end
      end
      default: begin
        if (restart) begin
          addr_d = addr_restart;
          state_d = IDLE;
        end else if (play_tick) begin
          audio_d = half_q;
          valid_d = 1'b1;
          addr_d = addr_next;
          state_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      word_dir_q <= 1'b1;
      restart_pending_q <= 1'b0;
      half_q <= '0;
      audio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      word_dir_q <= word_dir_d;
      restart_pending_q <= restart_pending_d;
      half_q <= half_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
    end
  end
  assign drop = play_tick && (state_q == REQ || state_q == WAIT_DATA);
`ifdef FLASH_READER_OVERRUN_CNT_EN
  logic [15:0] overrun_q, overrun_d;
  assign overrun_d = (drop && overrun_q != 16'hFFFF) ? overrun_q + 16'd1 : overrun_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_q <= '0;
    else overrun_q <= overrun_d;
  end
  assign overrun_cnt = overrun_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
  assign mem.read = state_q == REQ;
  assign mem.address = addr_q;
  assign mem.byteenable = 4'hF;
  assign audio_data = audio_q;
  assign audio_valid = valid_q;
  assign flash_read_finished = valid_q;
endmodule

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: directed checks of playback, wrap, stall, restart, pause and async reset.
module tb_flash_sample_reader;
  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, start = 1'b0, dir = 1'b1, restart = 1'b0;
  logic wr = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [31:0] rd_word = '0, d1 = '0, d2 = '0;
  logic [15:0] audio_data;
  logic audio_valid, frf;
  int pass = 0, total = 0, nvalid = 0, nfrf = 0, nv;
`ifdef FLASH_READER_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif
  flash_sample_reader_if #(.ADDR_W(23)) bus ();
  flash_sample_reader dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(tick), .start_read_flash(start), .dir(dir),
    .restart(restart), .mem(bus), .audio_data(audio_data), .audio_valid(audio_valid),
    .flash_read_finished(frf)
`ifdef FLASH_READER_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  // flash model: zero or stalled waitrequest, 2-clk read latency, returns rd_word
  assign bus.waitrequest = wr;
  assign bus.readdatavalid = v2;
  assign bus.readdata = d2;
  always @(posedge clk) begin
    v1 <= bus.read && !wr;
    d1 <= rd_word;
    v2 <= v1;
    d2 <= d1;
    if (audio_valid) nvalid <= nvalid + 1;
    if (frf) nfrf <= nfrf + 1;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !audio_valid; i++) step();
    chk(tag, 32'(audio_valid), 32'd1);
  endtask
  initial begin
    step();
    step();
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_addr", 32'(bus.address), 32'd0);
    chk("rst_be", 32'(bus.byteenable), 32'hF);
    chk("rst_audio", 32'(audio_data), 32'd0);
    chk("rst_valid", 32'(audio_valid), 32'd0);
    chk("rst_frf", 32'(frf), 32'd0);
    reset_n = 1'b1;
    step();
    start = 1'b1;
    dir = 1'b1;
    rd_word = 32'hBBBB_AAAA;
    pulse_tick();
    chk("fwd_read_lat", 32'(bus.read), 32'd1);
    chk("fwd_addr0", 32'(bus.address), 32'd0);
    wait_valid("fwd_first_valid");
    chk("fwd_first", 32'(audio_data), 32'hAAAA);
    chk("fwd_frf", 32'(frf), 32'd1);
    pulse_tick();
    chk("fwd_second_valid", 32'(audio_valid), 32'd1);
    chk("fwd_second", 32'(audio_data), 32'hBBBB);
    chk("fwd_addr1", 32'(bus.address), 32'd1);
    step();
    chk("fwd_valid_pulse", 32'(audio_valid), 32'd0);
    chk("fwd_nvalid", 32'(nvalid), 32'd2);
    chk("fwd_nfrf", 32'(nfrf), 32'd2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    dir = 1'b0;
    rd_word = 32'h1234_5678;
    pulse_tick();
    wait_valid("bwd_first_valid");
    chk("bwd_first", 32'(audio_data), 32'h1234);
    pulse_tick();
    chk("bwd_second", 32'(audio_data), 32'h5678);
    chk("bwd_wrap", 32'(bus.address), 32'h7FFFF);
    step();
    dir = 1'b1;
    wr = 1'b1;
    rd_word = 32'hCAFE_F00D;
    nv = nvalid;
    pulse_tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_read", 32'(bus.read), 32'd1);
      chk("stall_addr", 32'(bus.address), 32'h7FFFF);
      tick = (i == 1);
      step();
    end
    tick = 1'b0;
    wr = 1'b0;
    chk("stall_read_held", 32'(bus.read), 32'd1);
    step();
    chk("stall_read_drop", 32'(bus.read), 32'd0);
    chk("stall_no_output", 32'(nvalid), 32'(nv));
`ifdef FLASH_READER_OVERRUN_CNT_EN
    chk("overrun_cnt", 32'(overrun_cnt), 32'd1);
`endif
    wait_valid("stall_valid");
    chk("stall_first", 32'(audio_data), 32'hF00D);
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      chk("pause_no_valid", 32'(audio_valid), 32'd0);
      chk("pause_hold", 32'(audio_data), 32'hF00D);
    end
    start = 1'b1;
    pulse_tick();
    chk("resume_valid", 32'(audio_valid), 32'd1);
    chk("resume_second", 32'(audio_data), 32'hCAFE);
    chk("fwd_wrap", 32'(bus.address), 32'd0);
    rd_word = 32'h0000_1111;
    for (int w = 0; w < 16; w++) begin
      pulse_tick();
      wait_valid("walk_valid");
      pulse_tick();
    end
    chk("walk_addr", 32'(bus.address), 32'h10);
    step();
    pulse_tick();
    step();
    chk("rs_in_wait", 32'(bus.read), 32'd0);
    nv = nvalid;
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rs_discard", 32'(nvalid), 32'(nv));
    chk("rs_addr", 32'(bus.address), 32'd0);
    chk("rs_read", 32'(bus.read), 32'd0);
    rd_word = 32'h5A5A_0110;
    pulse_tick();
    chk("rs_idle_read", 32'(bus.read), 32'd1);
    chk("rs_idle_addr", 32'(bus.address), 32'd0);
    wait_valid("rs_next_valid");
    chk("rs_next", 32'(audio_data), 32'h0110);
    step();
    dir = 1'b0;
    restart = 1'b1;
    tick = 1'b1;
    step();
    restart = 1'b0;
    tick = 1'b0;
    chk("rs_tick_valid", 32'(audio_valid), 32'd0);
    chk("rs_tick_hold", 32'(audio_data), 32'h0110);
    chk("rs_tick_addr", 32'(bus.address), 32'h7FFFF);
    step();
    chk("rs_tick_read", 32'(bus.read), 32'd0);
    pulse_tick();
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_read", 32'(bus.read), 32'd0);
    chk("arst_addr", 32'(bus.address), 32'd0);
    chk("arst_audio", 32'(audio_data), 32'd0);
    chk("arst_valid", 32'(audio_valid), 32'd0);
    step();
    reset_n = 1'b1;
    nv = nvalid;
    for (int i = 0; i < 4; i++) step();
    chk("arst_late_rdv", 32'(nvalid), 32'(nv));
    chk("arst_audio_hold", 32'(audio_data), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
